hazard_scoreboard: RTL and testbench

Parametrised successor to the single-issue pipeline hazard/forwarding logic. It keeps its own shift-register scoreboard of in-flight destination registers, so it no longer needs per-stage writeReg/regWrite taps. From that scoreboard it generates forwarding selects for any number of post-ID stages, load-use stalls at a configurable data-ready stage, and multi-cycle MUL/DIV busy interlocks. Sits beside the ID-stage decoder; consumes decoded ID fields and drives IF/ID enables, the ID flush and the EX bubble.

---
 rtl/hazard_scoreboard.sv | 135 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: tracks in-flight destinations in a shift scoreboard and
// derives forwarding selects, load-use stalls and MUL/DIV busy interlocks.
module hazard_scoreboard #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned LOAD_STAGE = 2,
   parameter int unsigned MULDIV_LAT = 8,
   parameter int unsigned FW         = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_wr_reg,
   input  logic              id_is_load,
   input  logic              id_is_store,
   input  logic              id_is_muldiv,
   input  logic              id_reads_hilo,
   input  logic              id_redirect,
   output logic              enable_if,
   output logic              enable_id,
   output logic              flush_id,
   output logic              bubble_ex,
   output logic [FW-1:0]     fwd_a,
   output logic [FW-1:0]     fwd_b,
   output logic              fwd_m,
   output logic              muldiv_busy,
   output logic [1:0]        stall_cause
);

   localparam int unsigned CW = $clog2(MULDIV_LAT + 1);

   logic [STAGES:1]   sb_v_q, sb_v_d;
   logic [STAGES:1]   sb_ld_q, sb_ld_d;
   logic [REG_AW-1:0] sb_reg_q [1:STAGES];
   logic [REG_AW-1:0] sb_reg_d [1:STAGES];
   logic [CW-1:0]     md_cnt_q, md_cnt_d;

   logic          rs_use, rt_use;
   logic [FW-1:0] rs_k, rt_k;
   logic          rs_ld_early, rt_ld_early, rt_k1_ld;
   logic          st_fwd, lu_stall, md_busy, md_stall, stall;

   // Youngest-match search: walking oldest to youngest lets the lowest stage win.
   always_comb begin : match
      rs_use      = id_valid & id_rs_used;
      rt_use      = id_valid & id_rt_used;
      rs_k        = '0;
      rt_k        = '0;
      rs_ld_early = 1'b0;
      rt_ld_early = 1'b0;
      rt_k1_ld    = 1'b0;
      for (int k = int'(STAGES); k >= 1; k--) begin
         if (rs_use && sb_v_q[k] && (sb_reg_q[k] == id_rs) && (id_rs != '0)) begin
            rs_k        = FW'(k);
            rs_ld_early = sb_ld_q[k] && (k < int'(LOAD_STAGE));
         end
         if (rt_use && sb_v_q[k] && (sb_reg_q[k] == id_rt) && (id_rt != '0)) begin
            rt_k        = FW'(k);
            rt_ld_early = sb_ld_q[k] && (k < int'(LOAD_STAGE));
            rt_k1_ld    = sb_ld_q[k] && (k == 1);
         end
      end
   end

   // Store data hazard on a load in EX is covered by the MEM->MEM path.
   always_comb begin : hazards
      st_fwd   = id_is_store & rt_k1_ld & (LOAD_STAGE == 2) & ~rs_ld_early;
      lu_stall = rs_ld_early | (rt_ld_early & ~st_fwd);
      md_busy  = (md_cnt_q != '0);
      md_stall = id_valid & (id_is_muldiv | id_reads_hilo) & md_busy;
      stall    = lu_stall | md_stall;
   end

   always_comb begin : next_state
      sb_v_d  = '0;
      sb_ld_d = '0;
      for (int k = 1; k <= int'(STAGES); k++) sb_reg_d[k] = '0;
      for (int k = 2; k <= int'(STAGES); k++) begin
         sb_v_d[k]   = sb_v_q[k-1];
         sb_ld_d[k]  = sb_ld_q[k-1];
         sb_reg_d[k] = sb_reg_q[k-1];
      end
      sb_v_d[1]   = id_valid & id_wr_en & (id_wr_reg != '0) & ~stall;
      sb_ld_d[1]  = id_is_load;
      sb_reg_d[1] = id_wr_reg;

      md_cnt_d = md_cnt_q;
      if (id_valid && id_is_muldiv && !stall) md_cnt_d = CW'(MULDIV_LAT);
      else if (md_busy)                       md_cnt_d = md_cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         sb_v_q   <= '0;
         sb_ld_q  <= '0;
         md_cnt_q <= '0;
         for (int k = 1; k <= int'(STAGES); k++) sb_reg_q[k] <= '0;
      end else begin
         sb_v_q   <= sb_v_d;
         sb_ld_q  <= sb_ld_d;
         md_cnt_q <= md_cnt_d;
         for (int k = 1; k <= int'(STAGES); k++) sb_reg_q[k] <= sb_reg_d[k];
      end
   end

   // Outputs held quiet while reset is asserted.
   always_comb begin : outputs
      enable_if   = 1'b0;
      enable_id   = 1'b0;
      flush_id    = 1'b0;
      bubble_ex   = 1'b0;
      fwd_a       = '0;
      fwd_b       = '0;
      fwd_m       = 1'b0;
      muldiv_busy = 1'b0;
      stall_cause = 2'b00;
      if (rst_n) begin
         enable_if   = ~stall;
         enable_id   = ~stall;
         bubble_ex   = stall;
         flush_id    = id_redirect & id_valid & ~stall;
         fwd_a       = rs_k;
         fwd_b       = rt_k;
         fwd_m       = st_fwd;
         muldiv_busy = md_busy;
         stall_cause = {md_stall, lu_stall};
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized
// traffic compared each cycle against a history-based model.
module tb_hazard_scoreboard;

   localparam int REG_AW     = 5;
   localparam int STAGES     = 3;
   localparam int LOAD_STAGE = 2;
   localparam int MULDIV_LAT = 8;
   localparam int FW         = $clog2(STAGES + 1);

   logic              clk;
   logic              rst_n;
   logic              id_valid, id_rs_used, id_rt_used, id_wr_en;
   logic [REG_AW-1:0] id_rs, id_rt, id_wr_reg;
   logic              id_is_load, id_is_store, id_is_muldiv, id_reads_hilo, id_redirect;
   logic              enable_if, enable_id, flush_id, bubble_ex, fwd_m, muldiv_busy;
   logic [FW-1:0]     fwd_a, fwd_b;
   logic [1:0]        stall_cause;

   hazard_scoreboard #(
      .REG_AW(REG_AW), .STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE),
      .MULDIV_LAT(MULDIV_LAT), .FW(FW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
      .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_is_store(id_is_store),
      .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
      .id_redirect(id_redirect), .enable_if(enable_if), .enable_id(enable_id),
      .flush_id(flush_id), .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .fwd_m(fwd_m), .muldiv_busy(muldiv_busy), .stall_cause(stall_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs, rt;
      logic              rsu, rtu, we;
      logic [REG_AW-1:0] wr;
      logic              ld, st, md, hilo, redir;
   } instr_t;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] r;
      logic              ld;
   } slot_t;

   // past[k-1] is what ID handed to the pipe k cycles ago (bubble if stalled)
   slot_t  past[$];
   int     since_md;
   instr_t cur;
   logic   exp_stall;
   logic   rst_val;
   int     n_chk, n_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic instr_t nop();
      instr_t i = '0;
      return i;
   endfunction
   function automatic instr_t alu(input int rd, input int rs, input int rt);
      instr_t i = '0;
      i.valid = 1'b1; i.rs = REG_AW'(rs); i.rt = REG_AW'(rt); i.rsu = 1'b1; i.rtu = 1'b1;
      i.we = 1'b1; i.wr = REG_AW'(rd);
      return i;
   endfunction
   function automatic instr_t lw(input int rt, input int base);
      instr_t i = '0;
      i.valid = 1'b1; i.rs = REG_AW'(base); i.rt = REG_AW'(rt); i.rsu = 1'b1;
      i.we = 1'b1; i.wr = REG_AW'(rt); i.ld = 1'b1;
      return i;
   endfunction
   function automatic instr_t sw(input int rt, input int base);
      instr_t i = '0;
      i.valid = 1'b1; i.rs = REG_AW'(base); i.rt = REG_AW'(rt); i.rsu = 1'b1; i.rtu = 1'b1;
      i.st = 1'b1;
      return i;
   endfunction
   function automatic instr_t mult(input int rs, input int rt);
      instr_t i = alu(0, rs, rt);
      i.we = 1'b0; i.md = 1'b1;
      return i;
   endfunction
   function automatic instr_t mfhi(input int rd);
      instr_t i = '0;
      i.valid = 1'b1; i.we = 1'b1; i.wr = REG_AW'(rd); i.hilo = 1'b1;
      return i;
   endfunction
   function automatic instr_t br(input int rs, input int rt, input logic taken);
      instr_t i = alu(0, rs, rt);
      i.we = 1'b0; i.redir = taken;
      return i;
   endfunction

   function automatic int young(input logic [REG_AW-1:0] r);
      if (r == '0) return 0;
      for (int k = 1; k <= STAGES; k++)
         if (past[k-1].v && past[k-1].r == r) return k;
      return 0;
   endfunction

   task automatic model_reset();
      past = {};
      for (int k = 0; k < STAGES; k++) past.push_back(slot_t'(0));
      since_md = 1000;
   endtask

   // Drive one ID instruction, then compare every output against the model.
   task automatic put(input instr_t in);
      int   ka, kb;
      logic lua, lub, e_m, lu, mds, busy;
      @(negedge clk);
      rst_n = rst_val; cur = in;
      id_valid = in.valid; id_rs = in.rs; id_rt = in.rt; id_rs_used = in.rsu;
      id_rt_used = in.rtu; id_wr_en = in.we; id_wr_reg = in.wr; id_is_load = in.ld;
      id_is_store = in.st; id_is_muldiv = in.md; id_reads_hilo = in.hilo;
      id_redirect = in.redir;
      #1;
      ka   = (in.valid && in.rsu) ? young(in.rs) : 0;
      kb   = (in.valid && in.rtu) ? young(in.rt) : 0;
      lua  = (ka != 0) && past[ka-1].ld && (ka < LOAD_STAGE);
      lub  = (kb != 0) && past[kb-1].ld && (kb < LOAD_STAGE);
      e_m  = in.st && lub && (kb == 1) && (LOAD_STAGE == 2) && !lua;
      lu   = lua || (lub && !e_m);
      busy = (since_md <= MULDIV_LAT);
      mds  = in.valid && (in.md || in.hilo) && busy;
      exp_stall = lu || mds;
      if (!rst_n) begin
         ka = 0; kb = 0; e_m = 0; lu = 0; mds = 0; busy = 0;
      end
      chk("enable_if",   32'(enable_if),   32'(rst_n && !exp_stall));
      chk("enable_id",   32'(enable_id),   32'(rst_n && !exp_stall));
      chk("bubble_ex",   32'(bubble_ex),   32'(rst_n && exp_stall));
      chk("flush_id",    32'(flush_id),    32'(rst_n && in.redir && in.valid && !exp_stall));
      chk("fwd_a",       32'(fwd_a),       32'(ka));
      chk("fwd_b",       32'(fwd_b),       32'(kb));
      chk("fwd_m",       32'(fwd_m),       32'(e_m));
      chk("muldiv_busy", 32'(muldiv_busy), 32'(busy));
      chk("stall_cause", 32'(stall_cause), 32'({mds, lu}));
   endtask

   task automatic tick();
      slot_t s;
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         s.v  = cur.valid && cur.we && (cur.wr != '0) && !exp_stall;
         s.r  = cur.wr;
         s.ld = cur.ld;
         past.push_front(s);
         void'(past.pop_back());
         if (cur.valid && cur.md && !exp_stall) since_md = 1;
         else if (since_md < 1000) since_md++;
      end
   endtask

   task automatic step(input instr_t i);
      put(i); tick();
   endtask

   task automatic drain();
      for (int n = 0; n < STAGES + 1; n++) step(nop());
   endtask

   initial begin
      instr_t r;
      n_chk = 0; n_err = 0;
      rst_n = 1'b0; rst_val = 1'b0; cur = '0; exp_stall = 1'b0;
      model_reset();
      put(alu(4, 3, 5));
      chk("reset_enable_if", 32'(enable_if), 0);
      tick();
      rst_val = 1'b1;

      // forwarding distance 1..4
      step(alu(3, 1, 2));
      put(alu(4, 3, 5)); chk("fwd_dist1", 32'(fwd_a), 1); chk("fwd_dist1_ns", 32'(stall_cause), 0); tick();
      drain();
      step(alu(8, 1, 2)); step(alu(20, 1, 2));
      put(alu(4, 8, 5)); chk("fwd_dist2", 32'(fwd_a), 2); tick();
      drain();
      step(alu(9, 1, 2)); step(alu(20, 1, 2)); step(alu(21, 1, 2));
      put(alu(4, 9, 5)); chk("fwd_dist3", 32'(fwd_a), 3); tick();
      drain();
      step(alu(10, 1, 2)); step(alu(20, 1, 2)); step(alu(21, 1, 2)); step(alu(22, 1, 2));
      put(alu(4, 10, 5)); chk("fwd_dist4", 32'(fwd_a), 0); tick();
      drain();

      // load-use
      step(lw(2, 7));
      put(alu(6, 2, 2)); chk("lu_cause", 32'(stall_cause), 1); chk("lu_bubble", 32'(bubble_ex), 1);
      chk("lu_enif", 32'(enable_if), 0); tick();
      put(alu(6, 2, 2)); chk("lu_fwd_a", 32'(fwd_a), 2); chk("lu_fwd_b", 32'(fwd_b), 2);
      chk("lu_resume", 32'(stall_cause), 0); tick();
      drain();

      // store data from load vs store base from load
      step(lw(2, 7));
      put(sw(2, 7)); chk("st_fwd_m", 32'(fwd_m), 1); chk("st_fwd_b", 32'(fwd_b), 1);
      chk("st_nostall", 32'(stall_cause), 0); tick();
      drain();
      step(lw(2, 7));
      put(sw(7, 2)); chk("st_base_stall", 32'(stall_cause), 1); chk("st_base_fwdm", 32'(fwd_m), 0); tick();
      put(sw(7, 2)); chk("st_base_fwd_a", 32'(fwd_a), 2); tick();
      drain();

      // mult then mfhi: exactly MULDIV_LAT stall cycles
      step(mult(1, 2));
      for (int n = 0; n < MULDIV_LAT; n++) begin
         put(mfhi(5)); chk("md_stall", 32'(stall_cause), 2); tick();
      end
      put(mfhi(5)); chk("md_release", 32'(stall_cause), 0); chk("md_busy_low", 32'(muldiv_busy), 0); tick();
      drain();

      // $0 never matches; younger of two writers wins
      step(alu(0, 1, 2));
      put(alu(4, 0, 0)); chk("r0_fwd_a", 32'(fwd_a), 0); chk("r0_fwd_b", 32'(fwd_b), 0); tick();
      step(lw(0, 7));
      put(alu(4, 0, 0)); chk("r0_no_lu", 32'(stall_cause), 0); tick();
      drain();
      step(alu(11, 1, 2)); step(alu(11, 1, 2));
      put(alu(4, 11, 11)); chk("young_wins", 32'(fwd_a), 1); tick();
      drain();

      // redirect held off by a stall
      step(lw(2, 7));
      put(br(2, 3, 1'b1)); chk("redir_stalled", 32'(flush_id), 0); tick();
      put(br(2, 3, 1'b1)); chk("redir_resumed", 32'(flush_id), 1); tick();
      drain();

      // reset in the middle of a MUL/DIV countdown
      step(mult(1, 2));
      put(mfhi(5)); chk("rst_pre_stall", 32'(stall_cause), 2); tick();
      rst_val = 1'b0;
      put(mfhi(5)); chk("rst_busy", 32'(muldiv_busy), 0); chk("rst_cause", 32'(stall_cause), 0); tick();
      rst_val = 1'b1;
      put(mfhi(5)); chk("rst_after", 32'(stall_cause), 0); chk("rst_after_en", 32'(enable_if), 1); tick();
      drain();

      // randomized traffic over a small register set
      for (int n = 0; n < 3000; n++) begin
         rst_val     = ($urandom_range(0, 249) != 0);
         r           = '0;
         r.valid     = ($urandom_range(0, 4) != 0);
         r.rs        = REG_AW'($urandom_range(0, 3));
         r.rt        = REG_AW'($urandom_range(0, 3));
         r.rsu       = 1'($urandom_range(0, 1));
         r.rtu       = 1'($urandom_range(0, 1));
         r.we        = 1'($urandom_range(0, 1));
         r.wr        = REG_AW'($urandom_range(0, 3));
         r.ld        = ($urandom_range(0, 2) == 0);
         r.st        = ($urandom_range(0, 3) == 0);
         r.md        = ($urandom_range(0, 11) == 0);
         r.hilo      = ($urandom_range(0, 5) == 0);
         r.redir     = ($urandom_range(0, 4) == 0);
         step(r);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
